// File: rtl/dac_driver.sv
// Parallel 8-bit DAC transmit driver: sample FIFO, divided DAC clock, falling-edge data update.
// Optional build macro DAC_TWOS_COMP_EN: input samples are two's complement and become offset binary on Data.
module dac_driver #(
  parameter int          DacClkDiv = 9,
  parameter int          FifoDepth = 8,
  parameter logic [7:0]  IdleCode  = 8'h80
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         Enable,
  input  logic [7:0]                   InData,
  input  logic                         InValid,
  output logic                         InReady,
  output logic [$clog2(FifoDepth):0]   Level,
  output logic                         Underflow,
  output logic [7:0]                   Data,
  output logic                         ClkOut
);

  localparam int AddrW = $clog2(FifoDepth);
  localparam int CntW  = (DacClkDiv > 0) ? $clog2(DacClkDiv + 1) : 1;
  localparam logic [CntW-1:0]  CntLast = CntW'(DacClkDiv);
  localparam logic [AddrW:0]   LvlFull = (AddrW + 1)'(FifoDepth);

  logic [CntW-1:0]  count;
  logic [AddrW-1:0] wr_ptr;
  logic [AddrW-1:0] rd_ptr;
  logic [7:0]       mem [FifoDepth];
  logic             run;
  logic             terminal;
  logic             update;
  logic             push;
  logic             pop;
  logic             empty;
  logic [7:0]       pop_code;

  // NOTE: InReady is a pure function of registers (run, Level), so upstream never sees a combinational path back from InValid.
  assign InReady = run && (Level != LvlFull);

  // The update edge is the one on which ClkOut goes 1->0; data is launched half a DAC period ahead of the latch.
  always_comb begin
    empty    = (Level == '0);
    terminal = (count == CntLast);
    update   = Enable && terminal && ClkOut;
    push     = InValid && InReady;
    pop      = update && !empty;
`ifdef DAC_TWOS_COMP_EN
    pop_code = {~mem[rd_ptr][7], mem[rd_ptr][6:0]};
`else
    pop_code = mem[rd_ptr];
`endif
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      run       <= 1'b0;
      count     <= '0;
      ClkOut    <= 1'b1;
      Data      <= IdleCode;
      Level     <= '0;
      Underflow <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      run       <= 1'b1;
      Underflow <= update && empty;

      if (!Enable) begin
        count  <= '0;
        ClkOut <= 1'b1;
        Data   <= IdleCode;
      end else if (terminal) begin
        count  <= '0;
        ClkOut <= ~ClkOut;
      end else begin
        count  <= count + 1'b1;
      end

      if (update) Data <= empty ? IdleCode : pop_code;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   Level <= Level + 1'b1;
        2'b01:   Level <= Level - 1'b1;
        default: Level <= Level;
      endcase
    end
  end

  // NOTE: sample storage has no reset; pointers define validity, so stale contents are never observed.
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= InData;
  end

endmodule

// File: tb/tb_dac_driver.sv
// Scoreboard bench for dac_driver: stimulus queues expected codes, a monitor compares at every ClkOut fall.
module tb_dac_driver;

  localparam int         DacClkDiv = 9;
  localparam int         FifoDepth = 8;
  localparam logic [7:0] IdleCode  = 8'h80;
  localparam int         Period    = 2 * (DacClkDiv + 1);

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       Enable;
  logic [7:0] InData;
  logic       InValid;
  logic       InReady;
  logic [3:0] Level;
  logic       Underflow;
  logic [7:0] Data;
  logic       ClkOut;

  dac_driver #(.DacClkDiv(DacClkDiv), .FifoDepth(FifoDepth), .IdleCode(IdleCode)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Enable(Enable), .InData(InData), .InValid(InValid),
    .InReady(InReady), .Level(Level), .Underflow(Underflow), .Data(Data), .ClkOut(ClkOut)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       uflow;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   stray    = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [7:0] dac_code(input logic [7:0] d);
`ifdef DAC_TWOS_COMP_EN
    return d ^ 8'h80;
`else
    return d;
`endif
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d, input int budget);
    logic rdy;
    InData  = d;
    InValid = 1'b1;
    for (int i = 0; i < budget; i++) begin
      rdy = InReady;
      tick();
      if (rdy) begin
        sb.push_back({1'b0, dac_code(d)});
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL push_timeout: word 0x%0h not accepted within %0d cycles", d, budget);
  endtask

  task automatic wait_fall(output int at_cyc);
    logic prev;
    prev = ClkOut;
    for (int i = 0; i < 3 * Period; i++) begin
      tick();
      if (prev === 1'b1 && ClkOut === 1'b0) begin
        at_cyc = cyc;
        return;
      end
      prev = ClkOut;
    end
    at_cyc = cyc;
    n_checks++;
    n_fail++;
    $display("FAIL fall_timeout: no ClkOut fall within %0d cycles", 3 * Period);
  endtask

  // Monitor: a fall caused by edge P is seen at the following negedge; Enable/Reset_n sampled
  // at P are the values seen one negedge earlier.
  logic       mon_prev_clk = 1'b1;
  logic       mon_en_prev  = 1'b0;
  logic       mon_rst_prev = 1'b0;
  logic [7:0] mon_fall_data = 8'h80;
  logic       mon_fall;
  logic       mon_rise;
  exp_t       mon_e;

  initial begin
    forever begin
      @(negedge Clk);
      mon_fall = mon_rst_prev && mon_prev_clk === 1'b1 && ClkOut === 1'b0;
      mon_rise = mon_prev_clk === 1'b0 && ClkOut === 1'b1;
      if (mon_fall) begin
        if (sb.size() > 0) mon_e = sb.pop_front();
        else               mon_e = {1'b1, IdleCode};
        check("fall_data", Data, mon_e.data);
        check("fall_underflow", Underflow, mon_e.uflow);
        mon_fall_data = Data;
      end else if (mon_rst_prev && Underflow !== 1'b0) begin
        stray++;
      end
      if (mon_rise && mon_en_prev && mon_rst_prev) check("rise_stable", Data, mon_fall_data);
      mon_prev_clk = ClkOut;
      mon_en_prev  = Enable;
      mon_rst_prev = Reset_n;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] words [9];
  int         t0, t1;
  logic       rdy;
  logic       accepted;

  initial begin
    words   = '{8'h00, 8'h7F, 8'h80, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    Reset_n = 1'b0;
    Enable  = 1'b0;
    InValid = 1'b0;
    InData  = 8'h00;

    // Reset state
    repeat (3) tick();
    check("reset_data", Data, 8'h80);
    check("reset_clkout", ClkOut, 1'b1);
    check("reset_level", Level, 0);
    check("reset_inready", InReady, 1'b0);
    check("reset_underflow", Underflow, 1'b0);
    Reset_n = 1'b1;
    tick();
    check("inready_after_release", InReady, 1'b1);

    // Streaming three samples
    Enable = 1'b1;
    push_word(8'h10, 4);
    push_word(8'h20, 4);
    push_word(8'h30, 4);
    InValid = 1'b0;
    check("stream_level_3", Level, 3);
    wait_fall(t0);
    check("stream_level_2", Level, 2);
    wait_fall(t1);
    check("stream_spacing_1", t1 - t0, Period);
    check("stream_level_1", Level, 1);
    t0 = t1;
    wait_fall(t1);
    check("stream_spacing_2", t1 - t0, Period);
    check("stream_level_0", Level, 0);

    // Underflow after drain
    t0 = t1;
    wait_fall(t1);
    check("uflow_spacing", t1 - t0, Period);
    check("uflow_pulse", Underflow, 1'b1);
    check("uflow_data", Data, 8'h80);
    tick();
    check("uflow_width", Underflow, 1'b0);
    t0 = t1;
    wait_fall(t1);
    check("uflow_repeat_spacing", t1 - t0, Period);
    check("uflow_repeat_pulse", Underflow, 1'b1);

    // Disabled: clock parked high, idle code, no pulses
    Enable = 1'b0;
    repeat (2) tick();
    check("disable_clkout", ClkOut, 1'b1);
    check("disable_data", Data, 8'h80);
    repeat (3 * Period) tick();
    check("disable_clkout_held", ClkOut, 1'b1);

    // Full FIFO while disabled, ninth word held
    for (int i = 0; i < 8; i++) push_word(words[i], 4);
    InData  = words[8];
    InValid = 1'b1;
    repeat (5) tick();
    check("full_inready", InReady, 1'b0);
    check("full_level", Level, 8);
    Enable   = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 2 * Period; i++) begin
      rdy = InReady;
      tick();
      if (rdy) begin
        sb.push_back({1'b0, dac_code(words[8])});
        accepted = 1'b1;
        break;
      end
    end
    InValid = 1'b0;
    check("ninth_accepted", accepted, 1'b1);
    check("ninth_after_first_pop", ClkOut, 1'b0);
    check("ninth_level", Level, 8);
    repeat (8) wait_fall(t1);
    check("full_drained_level", Level, 0);
    wait_fall(t1);
    check("full_then_underflow", Underflow, 1'b1);

    // Simultaneous push and pop with Level=3
    Enable = 1'b0;
    tick();
    push_word(8'hA1, 4);
    push_word(8'hA2, 4);
    push_word(8'hA3, 4);
    InValid = 1'b0;
    check("simul_pre_level", Level, 3);
    Enable = 1'b1;
    repeat (9) tick();
    InData  = 8'hA4;
    InValid = 1'b1;
    tick();
    InValid = 1'b0;
    sb.push_back({1'b0, dac_code(8'hA4)});
    check("simul_is_update", ClkOut, 1'b0);
    check("simul_level", Level, 3);
    push_word(8'hA5, 4);
    push_word(8'hA6, 4);
    InValid = 1'b0;
    check("pre_reset_level", Level, 5);

    // Mid-operation reset discards queued samples
    sb.delete();
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    t0 = cyc;
    check("midreset_level", Level, 0);
    check("midreset_data", Data, 8'h80);
    check("midreset_clkout", ClkOut, 1'b1);
    check("midreset_inready", InReady, 1'b0);
    wait_fall(t1);
    check("midreset_first_fall", t1 - t0, DacClkDiv + 1);
    check("midreset_fall_underflow", Underflow, 1'b1);

    Enable = 1'b0;
    repeat (4) tick();
    check("no_stray_underflow", stray, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
